// File: rtl/sobel_ctrl_pkg.sv
// Shared sobel project constants: frame geometry, edge threshold and RGB332 output levels.
// The display stage reads PIC_SIZE as its picture size.
package sobel_ctrl_pkg;

  localparam logic [9:0]  IMG_W_C     = 10'd100;
  localparam logic [9:0]  IMG_H_C     = 10'd100;
  localparam logic [10:0] THRESHOLD_C = 11'd300;
  localparam logic [7:0]  EDGE_PIX_C  = 8'hFF;
  localparam logic [7:0]  BACK_PIX_C  = 8'h00;
  localparam int unsigned PIC_SIZE    = (100 - 2) * (100 - 2);

  // Magnitude of an 11-bit signed gradient; |-1020| still fits in 11 bits.
  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    logic signed [10:0] neg;
    neg = -v;
    return v[10] ? 11'(neg) : 11'(v);
  endfunction

endpackage

// File: rtl/sobel_ctrl_if.sv
// Pixel stream in / thresholded pixel stream out between camera side and display side.
interface sobel_ctrl_if;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic [7:0] po_data;
  logic       po_flag;

  modport master (output pi_data, output pi_flag, input po_data, input po_flag);
  modport slave  (input pi_data, input pi_flag, output po_data, output po_flag);
endinterface

// File: rtl/sobel_ctrl_line_buf.sv
// One image line of 8-bit pixels: single write port, asynchronous read.
// Contents are never reset; window gating makes stale data harmless.
module line_buf #(
  parameter int unsigned DEPTH = 100,
  parameter int unsigned AW    = 7
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Write the addressed column on each accepted pixel.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sobel_ctrl.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a shifting window,
// followed by gradient, magnitude and threshold stages (pi_flag to po_flag = 3 edges).
module sobel_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter logic [9:0]  IMG_W     = IMG_W_C,
  parameter logic [9:0]  IMG_H     = IMG_H_C,
  parameter logic [10:0] THRESHOLD = THRESHOLD_C,
  parameter logic [7:0]  EDGE_PIX  = EDGE_PIX_C,
  parameter logic [7:0]  BACK_PIX  = BACK_PIX_C
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  sobel_ctrl_if.slave bus
);

  localparam int unsigned W_INT = int'(IMG_W);
  localparam int unsigned AW    = (W_INT > 1) ? $clog2(W_INT) : 1;

  logic [9:0]  r_col, r_row, w_col_nxt, w_row_nxt;
  logic        w_col_last, w_row_last, w_win_ok;
  logic [7:0]  w_buf1, w_buf2;
  logic [7:0]  r_win [3][3];
  logic [10:0] w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic signed [10:0] r_gx, r_gy;
  logic [10:0] r_g;
  logic        r_v1, r_v2, r_v3;
  logic [7:0]  r_po_data;
  logic        r_po_flag;

  assign w_col_last = (r_col == IMG_W - 10'd1);
  assign w_row_last = (r_row == IMG_H - 10'd1);
  assign w_win_ok   = bus.pi_flag && (r_row >= 10'd2) && (r_col >= 10'd2);

  // Raster position advance, wrapping into the next frame after the last pixel.
  always_comb begin
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (bus.pi_flag) begin
      if (w_col_last) begin
        w_col_nxt = 10'd0;
        w_row_nxt = w_row_last ? 10'd0 : r_row + 10'd1;
      end else begin
        w_col_nxt = r_col + 10'd1;
      end
    end else begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_col <= 10'd0;
      r_row <= 10'd0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // buf1 holds row-1, buf2 holds row-2; both are read before the shared-edge write.
  line_buf #(.DEPTH(W_INT), .AW(AW)) u_buf1 (
    .i_clk(sys_clk), .i_we(bus.pi_flag), .i_addr(r_col[AW-1:0]),
    .i_wdata(bus.pi_data), .o_rdata(w_buf1)
  );
  line_buf #(.DEPTH(W_INT), .AW(AW)) u_buf2 (
    .i_clk(sys_clk), .i_we(bus.pi_flag), .i_addr(r_col[AW-1:0]),
    .i_wdata(w_buf1), .o_rdata(w_buf2)
  );

  // Window shifts left on each pixel; r_win[row][col], row 0 is the oldest line.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= 8'h00;
        end
      end
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_win_ok;
      if (bus.pi_flag) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= w_buf2;
        r_win[1][2] <= w_buf1;
        r_win[2][2] <= bus.pi_data;
      end
    end
  end

  assign w_gx_pos = {3'b000, r_win[0][2]} + {2'b00, r_win[1][2], 1'b0} + {3'b000, r_win[2][2]};
  assign w_gx_neg = {3'b000, r_win[0][0]} + {2'b00, r_win[1][0], 1'b0} + {3'b000, r_win[2][0]};
  assign w_gy_pos = {3'b000, r_win[0][0]} + {2'b00, r_win[0][1], 1'b0} + {3'b000, r_win[0][2]};
  assign w_gy_neg = {3'b000, r_win[2][0]} + {2'b00, r_win[2][1], 1'b0} + {3'b000, r_win[2][2]};

  // Gradient, magnitude and threshold stages; data regs hold while their valid is low.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_gx      <= 11'sd0;
      r_gy      <= 11'sd0;
      r_g       <= 11'd0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_po_flag <= 1'b0;
      r_po_data <= 8'h00;
    end else begin
      r_v2      <= r_v1;
      r_v3      <= r_v2;
      r_po_flag <= r_v3;
      if (r_v1) begin
        r_gx <= $signed(w_gx_pos - w_gx_neg);
        r_gy <= $signed(w_gy_pos - w_gy_neg);
      end
      if (r_v2) begin
        r_g <= abs11(r_gx) + abs11(r_gy);
      end
      if (r_v3) begin
        r_po_data <= (r_g >= THRESHOLD) ? EDGE_PIX : BACK_PIX;
      end
    end
  end

  assign bus.po_data = r_po_data;
  assign bus.po_flag = r_po_flag;

endmodule

// File: tb/tb_sobel_ctrl.sv
// Scoreboard bench for sobel_ctrl: a frame-array reference model queues expected pixels,
// a monitor pops and compares them with their due cycle.
module tb_sobel_ctrl;

  localparam int W   = 100;
  localparam int H   = 100;
  localparam int THR = 300;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  sobel_ctrl_if bus ();

  sobel_ctrl dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [7:0] img [H][W];
  int cyc = 0, m_row = 0, m_col = 0, cap202 = 0;
  int compared = 0, failed = 0;
  int pulses = 0, ff_cnt = 0, first_out = -1;
  logic [7:0] last_exp = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: keeps the frame as a 2-D array and applies the Sobel formulas directly.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_row = 0;
      m_col = 0;
      exp_q.delete();
    end else if (bus.pi_flag) begin
      img[m_row][m_col] = bus.pi_data;
      if (m_row == 2 && m_col == 2) cap202 = cyc;
      if (m_row >= 2 && m_col >= 2) begin
        int a [3][3];
        int gx, gy, g;
        exp_t e;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            a[i][j] = int'(img[m_row-2+i][m_col-2+j]);
        gx = (a[0][2] + 2*a[1][2] + a[2][2]) - (a[0][0] + 2*a[1][0] + a[2][0]);
        gy = (a[0][0] + 2*a[0][1] + a[0][2]) - (a[2][0] + 2*a[2][1] + a[2][2]);
        g  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        e.data = (g >= THR) ? 8'hFF : 8'h00;
        e.due  = cyc + 3;
        exp_q.push_back(e);
      end
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  end

  // Monitor: compares every output pulse and checks po_data holds between pulses.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      last_exp = 8'h00;
    end else if (bus.po_flag) begin
      pulses++;
      if (bus.po_data == 8'hFF) ff_cnt++;
      if (first_out < 0) first_out = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_po_flag", 1, 0);
        last_exp = bus.po_data;
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("po_data", int'(bus.po_data), int'(e.data));
        check("po_latency", cyc, e.due);
        last_exp = e.data;
      end
    end else begin
      check("po_hold", int'(bus.po_data), int'(last_exp));
    end
  end

  function automatic logic [7:0] pix(input int kind, input int r, input int c);
    case (kind)
      0: return 8'h80;
      1: return (c < 50) ? 8'd0 : 8'd255;
      2: return (r < 50) ? 8'd0 : 8'd75;
      3: return (r < 50) ? 8'd0 : 8'd74;
      5: return (c < 50) ? 8'd255 : 8'd0;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic send_frame(input int kind, input int gap, input int npix);
    for (int idx = 0; idx < npix; idx++) begin
      int r, c;
      r = (idx / W) % H;
      c = idx % W;
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
        @(negedge clk);
        bus.pi_flag = 1'b0;
      end
      @(negedge clk);
      bus.pi_flag = 1'b1;
      bus.pi_data = pix(kind, r, c);
    end
  endtask

  task automatic stop_and_drain();
    @(negedge clk);
    bus.pi_flag = 1'b0;
    repeat (8) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic clear_counts();
    pulses    = 0;
    ff_cnt    = 0;
    first_out = -1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.pi_flag = 1'b0;
    bus.pi_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_po_flag", int'(bus.po_flag), 0);
    check("reset_po_data", int'(bus.po_data), 0);
    rst_n = 1'b1;

    // Flat frame, continuous strobe: no edges, first output 3 edges after pixel 202.
    clear_counts();
    send_frame(0, 0, W*H);
    stop_and_drain();
    check("flat_pulses", pulses, 9604);
    check("flat_edges", ff_cnt, 0);
    check("flat_first_latency", first_out - cap202, 3);

    // Horizontal steps right at and just below the threshold.
    clear_counts();
    send_frame(2, 0, W*H);
    stop_and_drain();
    check("h75_pulses", pulses, 9604);
    check("h75_edges", ff_cnt, 196);
    clear_counts();
    send_frame(3, 0, W*H);
    stop_and_drain();
    check("h74_pulses", pulses, 9604);
    check("h74_edges", ff_cnt, 0);

    // Mid-frame reset with pixels in flight, then a random frame with gaps.
    send_frame(4, 0, 5000);
    @(negedge clk);
    bus.pi_flag = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_po_flag", int'(bus.po_flag), 0);
    check("midrst_po_data", int'(bus.po_data), 0);
    rst_n = 1'b1;
    clear_counts();
    send_frame(4, 10, W*H);
    stop_and_drain();
    check("rand_pulses", pulses, 9604);
    check("rand_first_latency", first_out - cap202, 3);

    // Back-to-back frames: vertical step then its inverse.
    clear_counts();
    send_frame(1, 0, W*H);
    send_frame(5, 0, W*H);
    stop_and_drain();
    check("b2b_pulses", pulses, 19208);
    check("b2b_edges", ff_cnt, 392);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sobel_ctrl.md
SOBEL_CTRL -- requirements
Module: sobel_ctrl

Interface
REQ-001 Parameter IMG_W, default 10'd100, input image width in pixels.
REQ-002 Parameter IMG_H, default 10'd100, input image height in pixels.
REQ-003 Parameter THRESHOLD, default 11'd300, gradient magnitude at or above which a pixel is an edge.
REQ-004 Parameter EDGE_PIX / BACK_PIX, defaults 8'hFF / 8'h00, RGB332 output values for edge / non-edge.
REQ-005 sys_clk  input  1  single clock for all logic.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 pi_data  input  8  grayscale input pixel, raster order.
REQ-008 pi_flag  input  1  pi_data valid strobe, one pixel per high cycle; back-to-back allowed.
REQ-009 po_data  output  8  thresholded Sobel pixel for the display-side write port.
REQ-010 po_flag  output  1  po_data valid strobe, one cycle per output pixel.

Function
REQ-011 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance only on pi_flag.
REQ-012 col SHALL wrap to 0 after IMG_W-1 and increment row; at col=IMG_W-1, row=IMG_H-1 both SHALL wrap to 0 (next frame).
REQ-013 Two line buffers SHALL hold rows row-1 (buf1) and row-2 (buf2); on pi_flag at col c: read both at c, then buf2[c]<=buf1[c], buf1[c]<=pi_data (read-before-write).
REQ-014 On pi_flag, a 3x3 window SHALL shift left one column, new right column = {buf2[c], buf1[c], pi_data} (top to bottom).
REQ-015 Window is valid on a pi_flag with row>=2 and col>=2; otherwise no output SHALL be produced.
REQ-016 Gx = (p13+2p23+p33)-(p11+2p21+p31), Gy = (p11+2p12+p13)-(p31+2p32+p33), 11-bit signed, no overflow.
REQ-017 G = |Gx|+|Gy|, 11-bit unsigned (max 2040), no saturation required.
REQ-018 po_data SHALL be EDGE_PIX if G>=THRESHOLD, else BACK_PIX.
REQ-019 Pipeline: window regs, Gx/Gy regs, G reg, output regs; a valid pi_flag in cycle T SHALL produce po_flag high in cycle T+3 exactly, no bubbles or stalls.
REQ-020 Each frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) = 9604 po_flag pulses, raster order, output row/col = input row-2/col-2.
REQ-021 po_data SHALL hold its last value while po_flag is low.
REQ-022 Rows 0-1 of each frame SHALL produce no output even though buffers hold the previous frame.

Reset
REQ-023 On reset: col, row = 0; all pipeline valid bits = 0; po_flag = 0; po_data = 8'h00; window and Gx/Gy/G regs = 0.
REQ-024 Line-buffer contents SHALL NOT require reset; REQ-015 gating makes them don't-care.
REQ-025 Reset mid-frame SHALL discard in-flight pixels; the next pi_flag is pixel (0,0) of a new frame.

Structure
REQ-026 IMG_W, IMG_H, THRESHOLD, EDGE_PIX, BACK_PIX SHALL come from the shared sobel project constants package, shared with the display stage (9604 = its picture size).
REQ-027 One sub-module line_buf: IMG_W x 8 register array, single write port, asynchronous read; instantiated twice.

Verification
REQ-028 Flat frame, all 10000 pixels = 8'h80 -> exactly 9604 po_flag pulses, all po_data = 8'h00.
REQ-029 Vertical step, cols 0-49 = 0, cols 50-99 = 255 -> every output row has 8'hFF at output cols 48 and 49 (G=1020), 8'h00 elsewhere.
REQ-030 Horizontal step, rows 0-49 = 0, rows 50-99 = 75 -> output rows 48, 49 = 8'hFF (G=300); same with 74 -> all 8'h00 (G=296).
REQ-031 Continuous pi_flag for 10000 cycles -> first po_flag exactly 3 cycles after pixel index 202 (row 2, col 2); 9604 pulses, none in rows 0-1.
REQ-032 Reset asserted after pixel 5000, then a full frame -> no po_flag before the new frame's pixel 202, then exactly 9604 pulses.
REQ-033 Two back-to-back frames, second an inverted step -> 19208 pulses total; second frame's output unaffected by first frame's buffer contents.
